// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: RUN/PAUSE/ADJ sequencing, MM:SS BCD counting and
// adjust-mode blink flags for the seven-segment multiplexer.
module stopwatch_ctrl #(
    parameter int MIN_MAX = 59,
    parameter int SEC_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_4hz,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       adjusting,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       wrap
);

    typedef enum logic [1:0] {
        PAUSE = 2'd0,
        RUN   = 2'd1,
        ADJ   = 2'd2
    } state_t;

    localparam logic [7:0] MIN_MAX_BCD = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
    localparam logic [7:0] SEC_MAX_BCD = {4'(SEC_MAX / 10), 4'(SEC_MAX % 10)};

    state_t     state, state_nxt;
    logic       resume, resume_nxt;
    logic       blink_phase;
    logic [7:0] min_bcd, sec_bcd;

    logic pause_p0, pause_p1, pause_p2;
    logic reset_p0, reset_p1, reset_p2;
    logic adj_p0, adj_p1;
    logic sel_p0, sel_p1;
    logic pause_edge, reset_edge;

    // Two-digit BCD increment that wraps to 00 once the field reaches its maximum.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Input synchronizers; the third button flop is the delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_p0 <= 1'b0;
            pause_p1 <= 1'b0;
            pause_p2 <= 1'b0;
            reset_p0 <= 1'b0;
            reset_p1 <= 1'b0;
            reset_p2 <= 1'b0;
            adj_p0   <= 1'b0;
            adj_p1   <= 1'b0;
            sel_p0   <= 1'b0;
            sel_p1   <= 1'b0;
        end else begin
            pause_p0 <= btn_pause;
            pause_p1 <= pause_p0;
            pause_p2 <= pause_p1;
            reset_p0 <= btn_reset;
            reset_p1 <= reset_p0;
            reset_p2 <= reset_p1;
            adj_p0   <= sw_adj;
            adj_p1   <= adj_p0;
            sel_p0   <= sw_sel;
            sel_p1   <= sel_p0;
        end
    end

    assign pause_edge = pause_p1 & ~pause_p2;
    assign reset_edge = reset_p1 & ~reset_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= PAUSE;
            resume <= 1'b0;
        end else begin
            state  <= state_nxt;
            resume <= resume_nxt;
        end
    end

    // The adjust switch outranks a pause edge arriving in the same cycle.
    always_comb begin
        state_nxt  = state;
        resume_nxt = resume;
        case (state)
            PAUSE: begin
                if (adj_p1) begin
                    state_nxt  = ADJ;
                    resume_nxt = 1'b0;
                end else if (pause_edge) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (adj_p1) begin
                    state_nxt  = ADJ;
                    resume_nxt = 1'b1;
                end else if (pause_edge) begin
                    state_nxt = PAUSE;
                end
            end
            ADJ: begin
                if (!adj_p1)
                    state_nxt = resume ? RUN : PAUSE;
            end
            default: state_nxt = PAUSE;
        endcase
    end

    // A reset edge clears the count ahead of any increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_bcd <= 8'h00;
            sec_bcd <= 8'h00;
            wrap    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (reset_edge) begin
                min_bcd <= 8'h00;
                sec_bcd <= 8'h00;
            end else if (state == RUN && tick_1hz) begin
                sec_bcd <= bcd_inc(sec_bcd, SEC_MAX_BCD);
                if (sec_bcd == SEC_MAX_BCD) begin
                    min_bcd <= bcd_inc(min_bcd, MIN_MAX_BCD);
                    if (min_bcd == MIN_MAX_BCD)
                        wrap <= 1'b1;
                end
            end else if (state == ADJ && tick_2hz) begin
                if (sel_p1)
                    min_bcd <= bcd_inc(min_bcd, MIN_MAX_BCD);
                else
                    sec_bcd <= bcd_inc(sec_bcd, SEC_MAX_BCD);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            blink_phase <= 1'b0;
        else if (state != ADJ && adj_p1)
            blink_phase <= 1'b0;
        else if (state == ADJ && tick_4hz)
            blink_phase <= ~blink_phase;
    end

    assign running   = (state == RUN);
    assign adjusting = (state == ADJ);
    assign blank_min = adjusting & sel_p1 & blink_phase;
    assign blank_sec = adjusting & ~sel_p1 & blink_phase;

    assign min_tens = min_bcd[7:4];
    assign min_ones = min_bcd[3:0];
    assign sec_tens = sec_bcd[7:4];
    assign sec_ones = sec_bcd[3:0];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized
// stimulus, all compared against an integer-arithmetic reference model.
module tb_stopwatch_ctrl;

    localparam int MIN_MAX = 59;
    localparam int SEC_MAX = 59;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_1hz = 1'b0, tick_2hz = 1'b0, tick_4hz = 1'b0;
    logic btn_pause = 1'b0, btn_reset = 1'b0, sw_adj = 1'b0, sw_sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic running, adjusting, blank_min, blank_sec, wrap;

    int total = 0;
    int bad = 0;

    stopwatch_ctrl #(.MIN_MAX(MIN_MAX), .SEC_MAX(SEC_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_4hz(tick_4hz),
        .btn_pause(btn_pause), .btn_reset(btn_reset), .sw_adj(sw_adj), .sw_sel(sw_sel),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .adjusting(adjusting), .blank_min(blank_min),
        .blank_sec(blank_sec), .wrap(wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1);
    end

    logic [20:0] dut_vec;
    assign dut_vec = {min_tens, min_ones, sec_tens, sec_ones,
                      running, adjusting, blank_min, blank_sec, wrap};

    // Reference model: state 0=paused 1=running 2=adjusting; counts as integers.
    int   m_state, m_min, m_sec;
    logic m_resume, m_blink, m_wrap;
    // Raw input history: h1 = value at the previous clock edge, h2/h3 older.
    logic ph1, ph2, ph3, rh1, rh2, rh3, ah1, ah2, ah3, sh1, sh2, sh3;

    task automatic m_reset();
        m_state = 0; m_min = 0; m_sec = 0;
        m_resume = 0; m_blink = 0; m_wrap = 0;
        {ph1, ph2, ph3, rh1, rh2, rh3, ah1, ah2, ah3, sh1, sh2, sh3} = '0;
    endtask

    task automatic m_step();
        logic pe, re, ad, sl;
        pe = ph2 & ~ph3;
        re = rh2 & ~rh3;
        ad = ah2;
        sl = sh2;
        m_wrap = 0;
        if (re) begin
            m_sec = 0;
            m_min = 0;
        end else if (m_state == 1 && tick_1hz) begin
            if (m_sec == SEC_MAX) begin
                m_sec = 0;
                if (m_min == MIN_MAX) begin
                    m_min = 0;
                    m_wrap = 1;
                end else m_min++;
            end else m_sec++;
        end else if (m_state == 2 && tick_2hz) begin
            if (sl) m_min = (m_min == MIN_MAX) ? 0 : m_min + 1;
            else    m_sec = (m_sec == SEC_MAX) ? 0 : m_sec + 1;
        end
        if (m_state != 2 && ad) m_blink = 0;
        else if (m_state == 2 && tick_4hz) m_blink = ~m_blink;
        if (m_state != 2) begin
            if (ad) begin
                m_resume = (m_state == 1);
                m_state = 2;
            end else if (pe) m_state = 1 - m_state;
        end else if (!ad) m_state = m_resume ? 1 : 0;
        ph3 = ph2; ph2 = ph1; ph1 = btn_pause;
        rh3 = rh2; rh2 = rh1; rh1 = btn_reset;
        ah3 = ah2; ah2 = ah1; ah1 = sw_adj;
        sh3 = sh2; sh2 = sh1; sh1 = sw_sel;
    endtask

    function automatic logic [20:0] exp_vec();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
                m_state == 1, m_state == 2,
                m_state == 2 && sh2 && m_blink, m_state == 2 && !sh2 && m_blink, m_wrap};
    endfunction

    // One clock: ticks set on the falling edge, outputs observable 1ns after rising edge.
    task automatic cyc(input logic t1, input logic t2, input logic t4);
        @(negedge clk);
        tick_1hz = t1; tick_2hz = t2; tick_4hz = t4;
        if (!rst_n) m_reset();
        else m_step();
        @(posedge clk);
        #1;
    endtask

    task automatic press_pause();
        btn_pause = 1;
        repeat (3) cyc(0, 0, 0);
        btn_pause = 0;
        cyc(0, 0, 0);
    endtask

    task automatic adj_set(input logic sel, input int target);
        int n;
        sw_sel = sel;
        sw_adj = 1;
        repeat (3) cyc(0, 0, 0);
        n = 0;
        while ((sel ? m_min : m_sec) != target && n < 120) begin
            cyc(0, 1, 0);
            n++;
        end
        total++;
        if (n >= 120) begin
            bad++;
            $display("FAIL adj_set_bound: got=%0d exp=%0d", sel ? m_min : m_sec, target);
        end
        sw_adj = 0;
        repeat (3) cyc(0, 0, 0);
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) begin
            cyc(1, 1, 1);
            total++;
            if (dut_vec !== 21'h0) begin
                bad++;
                $display("FAIL reset_hold: got=%h exp=%h", dut_vec, 21'h0);
            end
        end
        rst_n = 1;
        repeat (4) begin
            cyc(1, 0, 0);
            total++;
            if (dut_vec !== 21'h0 || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL reset_release: got=%h exp=%h", dut_vec, 21'h0);
            end
        end
    endtask

    task automatic test_preload();
        press_pause();
        total++;
        if (running !== 1'b1) begin
            bad++;
            $display("FAIL pause_to_run: got=%b exp=1", running);
        end
        adj_set(0, 58);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones, running} !== {16'h0058, 1'b1}) begin
            bad++;
            $display("FAIL preload_58: got=%h%h%h%h run=%b exp=0058 run=1",
                     min_tens, min_ones, sec_tens, sec_ones, running);
        end
        cyc(1, 0, 0);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0059 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL count_59: got=%h exp=%h", dut_vec, exp_vec());
        end
        cyc(0, 0, 0);
        cyc(1, 0, 0);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0100 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL count_carry: got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_wrap();
        adj_set(1, 59);
        adj_set(0, 59);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h5959) begin
            bad++;
            $display("FAIL preload_5959: got=%h%h%h%h exp=5959",
                     min_tens, min_ones, sec_tens, sec_ones);
        end
        cyc(1, 0, 0);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones, wrap} !== {16'h0000, 1'b1}
            || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL wrap_pulse: got=%h exp=%h", dut_vec, exp_vec());
        end
        cyc(0, 0, 0);
        total++;
        if (wrap !== 1'b0) begin
            bad++;
            $display("FAIL wrap_one_cycle: got=%b exp=0", wrap);
        end
    endtask

    task automatic test_pause();
        cyc(1, 0, 0);
        press_pause();
        total++;
        if (running !== 1'b0) begin
            bad++;
            $display("FAIL pause_stop: got=%b exp=0", running);
        end
        repeat (5) begin
            cyc(1, 0, 0);
            total++;
            if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0001 || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL paused_hold: got=%h exp=%h", dut_vec, exp_vec());
            end
        end
        press_pause();
        cyc(1, 0, 0);
        total++;
        if ({running, min_tens, min_ones, sec_tens, sec_ones} !== {1'b1, 16'h0002}) begin
            bad++;
            $display("FAIL resume_count: got=%h exp=%h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_adjust();
        logic [7:0] sec_before;
        logic       prev_blank;
        int n;
        sec_before = {sec_tens, sec_ones};
        sw_sel = 1;
        sw_adj = 1;
        repeat (3) cyc(1, 0, 0);
        n = 0;
        while (m_min != 58 && n < 120) begin
            cyc(0, 1, 0);
            n++;
        end
        sec_before = {sec_tens, sec_ones};
        cyc(0, 1, 0);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones, wrap} !== {8'h59, sec_before, 1'b0}) begin
            bad++;
            $display("FAIL adj_min_59: got=%h exp=%h", dut_vec, exp_vec());
        end
        cyc(1, 1, 0);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones, wrap} !== {8'h00, sec_before, 1'b0}
            || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL adj_min_wrap: got=%h exp=%h", dut_vec, exp_vec());
        end
        prev_blank = blank_min;
        repeat (4) begin
            cyc(0, 0, 1);
            total++;
            if (blank_min !== ~prev_blank || blank_sec !== 1'b0 || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL blink: got=%b%b exp=%b0", blank_min, blank_sec, ~prev_blank);
            end
            prev_blank = blank_min;
        end
        press_pause();
        total++;
        if (adjusting !== 1'b1 || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL adj_ignore_pause: got=%h exp=%h", dut_vec, exp_vec());
        end
        sw_adj = 0;
        repeat (3) cyc(0, 0, 1);
        total++;
        if ({running, adjusting, blank_min, blank_sec} !== 4'b1000) begin
            bad++;
            $display("FAIL adj_exit_run: got=%b exp=1000",
                     {running, adjusting, blank_min, blank_sec});
        end
    endtask

    task automatic test_reset_edge();
        adj_set(1, 12);
        adj_set(0, 34);
        btn_reset = 1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        total++;
        if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h1234) begin
            bad++;
            $display("FAIL preload_1234: got=%h exp=%h", dut_vec, exp_vec());
        end
        cyc(1, 0, 0);
        total++;
        if (dut_vec !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0} || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL reset_edge_tick: got=%h exp=%h", dut_vec, exp_vec());
        end
        btn_reset = 0;
        cyc(1, 0, 0);
        btn_reset = 1;
        btn_pause = 1;
        repeat (3) cyc(0, 0, 0);
        total++;
        if ({running, min_tens, min_ones, sec_tens, sec_ones} !== {1'b0, 16'h0000}
            || dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL pause_and_reset: got=%h exp=%h", dut_vec, exp_vec());
        end
        btn_reset = 0;
        btn_pause = 0;
        cyc(0, 0, 0);
    endtask

    task automatic test_async_reset();
        press_pause();
        repeat (3) cyc(1, 0, 0);
        #2;
        rst_n = 0;
        #1;
        m_reset();
        total++;
        if (dut_vec !== 21'h0) begin
            bad++;
            $display("FAIL async_reset: got=%h exp=%h", dut_vec, 21'h0);
        end
        cyc(1, 0, 0);
        rst_n = 1;
        repeat (3) begin
            cyc(1, 0, 0);
            total++;
            if (dut_vec !== 21'h0 || dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL after_async_reset: got=%h exp=%h", dut_vec, 21'h0);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 79) == 0) btn_reset = ~btn_reset;
            if ($urandom_range(0, 119) == 0) sw_adj = ~sw_adj;
            if ($urandom_range(0, 29) == 0) sw_sel = ~sw_sel;
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random[%0d]: got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_preload();
        test_wrap();
        test_pause();
        test_adjust();
        test_reset_edge();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
